// File: rtl/gb_mem_pkg.sv
// Shared Game Boy memory-map constants and DMA state encoding.
// Used by the OAM DMA engine; the MMU and PPU import the same definitions.
package gb_mem_pkg;

  localparam logic [15:0] OAM_BASE      = 16'hFE00;
  localparam int          OAM_LEN       = 160;
  localparam logic [15:0] DMA_REG_ADDR  = 16'hFF46;
  localparam logic [15:0] BUS_IDLE_ADDR = 16'hFFFF;

  typedef enum logic [1:0] {
    DMA_IDLE,
    DMA_START,
    DMA_XFER
  } dma_state_t;

endpackage

// File: rtl/mem_if.sv
// Simple byte-wide memory port: one address, write strobe and data, read data back.
interface mem_if;
  logic [15:0] addr_select;
  logic [7:0]  write_value;
  logic [7:0]  read_out;
  logic        write_enable;

  modport master (output addr_select, output write_value, output write_enable, input read_out);
  modport slave  (input addr_select, input write_value, input write_enable, output read_out);
endinterface

// File: rtl/oam_dma_engine.sv
// OAM DMA controller owning register FF46: copies XX00-XX9F into FE00-FE9F over dma_req.
// Optional OAM_DMA_ECHO_MIRROR_EN remaps source pages E0-FF down by 0x20 (echo RAM).
module oam_dma_engine
  import gb_mem_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int BYTE_PERIOD  = 4,
  parameter int START_DELAY  = 4
) (
  input  logic  clk,
  input  logic  rst,
  mem_if.slave  mmio_dma_if,
  mem_if.master dma_req,
  output logic  busy
);

  localparam int PW = (BYTE_PERIOD > 1) ? $clog2(BYTE_PERIOD) : 1;
  localparam int DW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam logic [PW-1:0] PH_LATCH = PW'(READ_LATENCY);
  localparam logic [PW-1:0] PH_WRITE = PW'(READ_LATENCY + 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(BYTE_PERIOD - 1);
  localparam logic [DW-1:0] DLY_LAST = DW'(START_DELAY - 1);
  localparam logic [7:0]    IDX_LAST = 8'(OAM_LEN - 1);

  generate
    if (BYTE_PERIOD < READ_LATENCY + 2) begin : g_bad_period
      $error("oam_dma_engine: BYTE_PERIOD must be >= READ_LATENCY+2");
    end
    if (START_DELAY < 1) begin : g_bad_delay
      $error("oam_dma_engine: START_DELAY must be >= 1");
    end
  endgenerate

  function automatic logic [7:0] map_src_page(input logic [7:0] page);
`ifdef OAM_DMA_ECHO_MIRROR_EN
    return (page >= 8'hE0) ? (page - 8'h20) : page;
`else
    return page;
`endif
  endfunction

  dma_state_t    state_reg;
  logic [7:0]    dma_reg;
  logic [7:0]    src_page_reg;
  logic [7:0]    idx_reg;
  logic [PW-1:0] phase_reg;
  logic [DW-1:0] delay_reg;
  logic [7:0]    data_q_reg;
  logic          reg_wr;

  assign reg_wr = mmio_dma_if.write_enable && (mmio_dma_if.addr_select == DMA_REG_ADDR);
  assign mmio_dma_if.read_out = (mmio_dma_if.addr_select == DMA_REG_ADDR) ? dma_reg : 8'h00;
  assign busy = (state_reg != DMA_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= DMA_IDLE;
      dma_reg      <= 8'hFF;
      src_page_reg <= 8'h00;
      idx_reg      <= 8'h00;
      phase_reg    <= '0;
      delay_reg    <= '0;
      data_q_reg   <= 8'h00;
    end else if (reg_wr) begin
      // A write in any state (re)starts; an in-flight byte before its write phase is dropped.
      dma_reg      <= mmio_dma_if.write_value;
      src_page_reg <= map_src_page(mmio_dma_if.write_value);
      state_reg    <= DMA_START;
      idx_reg      <= 8'h00;
      phase_reg    <= '0;
      delay_reg    <= '0;
    end else begin
      case (state_reg)
        DMA_START: begin
          if (delay_reg == DLY_LAST) begin
            state_reg <= DMA_XFER;
            phase_reg <= '0;
          end else begin
            delay_reg <= delay_reg + 1'b1;
          end
        end
        DMA_XFER: begin
          if (phase_reg == PH_LATCH) begin
            data_q_reg <= dma_req.read_out;
          end
          if (phase_reg == PH_LAST) begin
            phase_reg <= '0;
            if (idx_reg == IDX_LAST) begin
              state_reg <= DMA_IDLE;
            end else begin
              idx_reg <= idx_reg + 8'h01;
            end
          end else begin
            phase_reg <= phase_reg + 1'b1;
          end
        end
        default: state_reg <= DMA_IDLE;
      endcase
    end
  end

  // Bus outputs decode straight from state so an async reset releases the bus at once.
  always_comb begin
    dma_req.addr_select  = BUS_IDLE_ADDR;
    dma_req.write_value  = 8'h00;
    dma_req.write_enable = 1'b0;
    case (state_reg)
      DMA_START: dma_req.addr_select = OAM_BASE;
      DMA_XFER: begin
        if (phase_reg <= PH_LATCH) begin
          dma_req.addr_select = {src_page_reg, idx_reg};
        end else begin
          dma_req.addr_select = OAM_BASE + {8'h00, idx_reg};
          if (phase_reg == PH_WRITE) begin
            dma_req.write_value  = data_q_reg;
            dma_req.write_enable = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_oam_dma_engine.sv
// Scoreboard bench for oam_dma_engine: source memory model, OAM capture, timing and restart checks.
// Expectations follow OAM_DMA_ECHO_MIRROR_EN when it is defined for the build.
module tb_oam_dma_engine;
  import gb_mem_pkg::*;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    int          cyc;
  } bus_ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy;

  mem_if mmio ();
  mem_if dreq ();

  oam_dma_engine dut (
    .clk         (clk),
    .rst         (rst),
    .mmio_dma_if (mmio),
    .dma_req     (dreq),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int busy_cnt = 0;
  bus_ev_t obs_q[$];
  bus_ev_t exp_q[$];
  bus_ev_t src_q[$];
  logic [7:0]  oam [0:255];
  logic [15:0] last_addr = 16'hFFFF;

  function automatic logic [7:0] src_byte(input logic [15:0] a);
    case (a[15:8])
      8'hC0:   return a[7:0] ^ 8'h5A;
      8'hD0:   return a[7:0] ^ 8'hA5;
      8'hC1:   return a[7:0] ^ 8'h3C;
      8'hE1:   return a[7:0] ^ 8'h96;
      default: return a[7:0] ^ 8'h77;
    endcase
  endfunction

  function automatic logic [7:0] tb_map(input logic [7:0] p);
`ifdef OAM_DMA_ECHO_MIRROR_EN
    if (p >= 8'hE0) return p - 8'h20;
`endif
    return p;
  endfunction

  // Memory model and bus monitor: registered reads, OAM capture, event logs.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    dreq.read_out <= src_byte(dreq.addr_select);
    if (busy) busy_cnt <= busy_cnt + 1;
    if (mmio.write_enable && mmio.addr_select == DMA_REG_ADDR) acc_cyc <= cyc;
    if (dreq.write_enable) begin
      obs_q.push_back('{addr: dreq.addr_select, data: dreq.write_value, cyc: cyc});
      if (dreq.addr_select[15:8] == 8'hFE) oam[dreq.addr_select[7:0]] <= dreq.write_value;
    end
    if (dreq.addr_select != last_addr && dreq.addr_select[15:8] != 8'hFE &&
        dreq.addr_select != BUS_IDLE_ADDR)
      src_q.push_back('{addr: dreq.addr_select, data: 8'h00, cyc: cyc});
    last_addr <= dreq.addr_select;
  end

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    mmio.addr_select  = a;
    mmio.write_value  = d;
    mmio.write_enable = 1'b1;
    @(negedge clk);
    mmio.write_enable = 1'b0;
    mmio.addr_select  = 16'h0000;
  endtask

  task automatic push_expected(input logic [7:0] page, input int count);
    for (int i = 0; i < count; i++)
      exp_q.push_back('{addr: 16'hFE00 + 16'(i), data: src_byte({page, 8'(i)}), cyc: 0});
  endtask

  task automatic wait_writes(input int n, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (obs_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic read_ff46(output logic [7:0] v);
    mmio.addr_select = DMA_REG_ADDR;
    #1 v = mmio.read_out;
    mmio.addr_select = 16'h0000;
  endtask

  task automatic test_reset;
    logic [7:0] v;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (dreq.addr_select !== 16'hFFFF || dreq.write_enable !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_bus: addr=%h we=%b busy=%b, required addr=ffff we=0 busy=0",
               dreq.addr_select, dreq.write_enable, busy);
    end
    read_ff46(v);
    vectors++;
    if (v !== 8'hFF) begin
      miscompares++;
      $display("FAIL reset_ff46: read %h, required ff", v);
    end
    mmio.addr_select = 16'hFF47;
    #1;
    vectors++;
    if (mmio.read_out !== 8'h00) begin
      miscompares++;
      $display("FAIL other_reg_read: read %h, required 00", mmio.read_out);
    end
    mmio.addr_select = 16'h0000;
    $display("test_reset: done");
  endtask

  task automatic test_basic_copy;
    bit ok;
    int b0, bad;
    bus_ev_t ev, ex;
    src_q.delete();
    b0 = busy_cnt;
    push_expected(8'hC0, 160);
    cpu_write(DMA_REG_ADDR, 8'hC0);
    wait_writes(10, ok);
    cpu_write(16'hFF47, 8'h12);
    wait_idle(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL basic_timeout: busy still %b, required 0 within budget", busy);
    end
    @(negedge clk);
    vectors++;
    if (busy_cnt - b0 != 644) begin
      miscompares++;
      $display("FAIL basic_busy_len: %0d clocks, required 644", busy_cnt - b0);
    end
    vectors++;
    if (dreq.addr_select !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL basic_release: addr=%h, required ffff", dreq.addr_select);
    end
    vectors++;
    if (oam[8'h9F] !== 8'hC5) begin
      miscompares++;
      $display("FAIL basic_fe9f: %h, required c5", oam[8'h9F]);
    end
    vectors++;
    if (src_q.size() != 160 || src_q[0].addr !== 16'hC000 || src_q[0].cyc - acc_cyc != 5) begin
      miscompares++;
      $display("FAIL first_src: n=%0d addr=%h at +%0d, required n=160 c000 at +5",
               src_q.size(), src_q.size() > 0 ? src_q[0].addr : 16'h0,
               src_q.size() > 0 ? src_q[0].cyc - acc_cyc : -1);
    end
    if (obs_q.size() > 0) begin
      vectors++;
      if (src_q.size() == 0 || obs_q[0].cyc - src_q[0].cyc != 2) begin
        miscompares++;
        $display("FAIL first_write_gap: %0d clocks after first read, required 2",
                 src_q.size() > 0 ? obs_q[0].cyc - src_q[0].cyc : -1);
      end
    end
    bad = 0;
    for (int i = 1; i < obs_q.size(); i++)
      if (obs_q[i].cyc - obs_q[i-1].cyc != 4) bad++;
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL write_spacing: %0d gaps differ, required all gaps 4 clocks", bad);
    end
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL basic_count: %0d we pulses, required %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      ev = obs_q.pop_front();
      ex = exp_q.pop_front();
      vectors++;
      if (ev.addr !== ex.addr || ev.data !== ex.data) begin
        miscompares++;
        $display("FAIL basic_write: got %h<=%h, required %h<=%h", ev.addr, ev.data, ex.addr, ex.data);
      end
    end
    obs_q.delete();
    exp_q.delete();
    $display("test_basic_copy: done");
  endtask

  task automatic test_restart;
    bit ok;
    int bad, j;
    logic [7:0] v;
    bus_ev_t ev, ex;
    src_q.delete();
    // Stimulus cuts the first transfer after 50 completed bytes.
    push_expected(8'hC0, 50);
    cpu_write(DMA_REG_ADDR, 8'hC0);
    wait_writes(50, ok);
    push_expected(8'hD0, 160);
    cpu_write(DMA_REG_ADDR, 8'hD0);
    wait_idle(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL restart_timeout: busy still %b, required 0 within budget", busy);
    end
    j = 0;
    while (j < src_q.size() && src_q[j].addr[15:8] == 8'hC0) j++;
    vectors++;
    if (j >= src_q.size() || src_q[j].addr !== 16'hD000 || src_q[j].cyc - acc_cyc != 5) begin
      miscompares++;
      $display("FAIL restart_src: next source %h at +%0d, required d000 at +5",
               j < src_q.size() ? src_q[j].addr : 16'h0, j < src_q.size() ? src_q[j].cyc - acc_cyc : -1);
    end
    bad = 0;
    for (int i = 0; i < 160; i++)
      if (oam[i] !== (8'(i) ^ 8'hA5)) bad++;
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL restart_oam: %0d bytes not from d0xx, required 0", bad);
    end
    read_ff46(v);
    vectors++;
    if (v !== 8'hD0) begin
      miscompares++;
      $display("FAIL restart_ff46: read %h, required d0", v);
    end
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL restart_count: %0d we pulses, required %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      ev = obs_q.pop_front();
      ex = exp_q.pop_front();
      vectors++;
      if (ev.addr !== ex.addr || ev.data !== ex.data) begin
        miscompares++;
        $display("FAIL restart_write: got %h<=%h, required %h<=%h", ev.addr, ev.data, ex.addr, ex.data);
      end
    end
    obs_q.delete();
    exp_q.delete();
    $display("test_restart: done");
  endtask

  task automatic test_async_reset;
    bit ok;
    logic [7:0] snap, v;
    bus_ev_t ev, ex;
    src_q.delete();
    // Reset is dropped once 80 bytes have landed.
    push_expected(8'hC0, 80);
    cpu_write(DMA_REG_ADDR, 8'hC0);
    wait_writes(80, ok);
    snap = oam[8'h50];
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (dreq.addr_select !== 16'hFFFF || dreq.write_enable !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_bus: addr=%h we=%b busy=%b, required ffff 0 0",
               dreq.addr_select, dreq.write_enable, busy);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    vectors++;
    if (oam[8'h50] !== snap) begin
      miscompares++;
      $display("FAIL abort_fe50: %h, required unchanged %h", oam[8'h50], snap);
    end
    read_ff46(v);
    vectors++;
    if (v !== 8'hFF) begin
      miscompares++;
      $display("FAIL abort_ff46: read %h, required ff", v);
    end
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL abort_count: %0d we pulses, required %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      ev = obs_q.pop_front();
      ex = exp_q.pop_front();
      vectors++;
      if (ev.addr !== ex.addr || ev.data !== ex.data) begin
        miscompares++;
        $display("FAIL abort_write: got %h<=%h, required %h<=%h", ev.addr, ev.data, ex.addr, ex.data);
      end
    end
    obs_q.delete();
    exp_q.delete();
    $display("test_async_reset: done");
  endtask

  task automatic test_echo_mirror;
    bit ok;
    logic [7:0] page, v;
    bus_ev_t ev, ex;
    src_q.delete();
    page = tb_map(8'hE1);
    push_expected(page, 160);
    cpu_write(DMA_REG_ADDR, 8'hE1);
    wait_idle(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL echo_timeout: busy still %b, required 0 within budget", busy);
    end
    vectors++;
    if (src_q.size() != 160 || src_q[0].addr !== {page, 8'h00} || src_q[159].addr !== {page, 8'h9F}) begin
      miscompares++;
      $display("FAIL echo_src: n=%0d first=%h, required n=160 %h..%h",
               src_q.size(), src_q.size() > 0 ? src_q[0].addr : 16'h0, {page, 8'h00}, {page, 8'h9F});
    end
    read_ff46(v);
    vectors++;
    if (v !== 8'hE1) begin
      miscompares++;
      $display("FAIL echo_ff46: read %h, required e1", v);
    end
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL echo_count: %0d we pulses, required %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      ev = obs_q.pop_front();
      ex = exp_q.pop_front();
      vectors++;
      if (ev.addr !== ex.addr || ev.data !== ex.data) begin
        miscompares++;
        $display("FAIL echo_write: got %h<=%h, required %h<=%h", ev.addr, ev.data, ex.addr, ex.data);
      end
    end
    obs_q.delete();
    exp_q.delete();
    $display("test_echo_mirror: done");
  endtask

  task automatic test_back_to_back;
    bit ok, hit;
    int b0;
    bus_ev_t ev, ex;
    src_q.delete();
    push_expected(8'hC0, 160);
    cpu_write(DMA_REG_ADDR, 8'hC0);
    hit = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (dreq.write_enable && dreq.addr_select == 16'hFE9F) begin
        hit = 1'b1;
        break;
      end
    end
    vectors++;
    if (!hit) begin
      miscompares++;
      $display("FAIL b2b_final_write: final write to fe9f not seen, required within budget");
    end
    // Register write lands on the same clock as the final OAM write.
    b0 = busy_cnt;
    mmio.addr_select  = DMA_REG_ADDR;
    mmio.write_value  = 8'hD0;
    mmio.write_enable = 1'b1;
    push_expected(8'hD0, 160);
    @(negedge clk);
    mmio.write_enable = 1'b0;
    mmio.addr_select  = 16'h0000;
    vectors++;
    if (busy !== 1'b1 || dreq.addr_select !== 16'hFE00) begin
      miscompares++;
      $display("FAIL b2b_restart: busy=%b addr=%h, required busy=1 addr=fe00", busy, dreq.addr_select);
    end
    wait_idle(ok);
    vectors++;
    if (!ok || busy_cnt - b0 != 645) begin
      miscompares++;
      $display("FAIL b2b_busy: %0d busy clocks since restart, required 645", busy_cnt - b0);
    end
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL b2b_count: %0d we pulses, required %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      ev = obs_q.pop_front();
      ex = exp_q.pop_front();
      vectors++;
      if (ev.addr !== ex.addr || ev.data !== ex.data) begin
        miscompares++;
        $display("FAIL b2b_write: got %h<=%h, required %h<=%h", ev.addr, ev.data, ex.addr, ex.data);
      end
    end
    obs_q.delete();
    exp_q.delete();
    $display("test_back_to_back: done");
  endtask

  initial begin
    mmio.addr_select  = 16'h0000;
    mmio.write_value  = 8'h00;
    mmio.write_enable = 1'b0;
    test_reset();
    test_basic_copy();
    test_restart();
    test_async_reset();
    test_echo_mirror();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/oam_dma_engine.md
Name: oam_dma_engine

Overview:
- Game Boy OAM DMA controller and owner of register DMA (0xFF46).
- The CPU writes a source page byte XX through the MMU's mmio_dma_if. The engine then copies 160 bytes, XX00–XX9F, into OAM at FE00–FE9F by mastering the MMU's dma_req port.
- It sits directly upstream of the MMU. While a transfer runs, the MMU blocks CPU access to VRAM, WRAM and OAM, because dma_req.addr_select is not 16'hFFFF.

Parameters:
- READ_LATENCY, 1: clocks from presenting a source address on dma_req to valid read_out (BRAM-backed regions).
- BYTE_PERIOD, 4: clocks per transferred byte. Must be >= READ_LATENCY+2; an elaboration-time assertion enforces this.
- START_DELAY, 4: clocks between the FF46 write and the first source read.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- mmio_dma_if  mem_if.slave  (addr 16, wdata 8, rdata 8, we 1)  CPU register port from the MMU
- dma_req  mem_if.master  (addr 16, wdata 8, rdata 8, we 1)  bus request into the MMU
- busy  out  1  high from the FF46 write accept until the last OAM write completes

Behaviour:
- Reset (rst low, async):
  - state=IDLE; dma_reg=8'hFF; busy=0.
  - dma_req.addr_select=16'hFFFF; write_value=0; write_enable=0.
  - Asserting rst mid-transfer aborts immediately and releases the bus. No further OAM writes occur.
- Register access:
  - Write accepted on the clk edge when mmio_dma_if.write_enable=1 and addr_select=16'hFF46. The edge latches dma_reg and src_page.
  - mmio_dma_if.read_out is combinational: dma_reg when addr_select=16'hFF46, else 8'h00.
- States: IDLE -> START -> XFER -> IDLE.
  - IDLE: bus released (addr 16'hFFFF, we 0). A register write goes to START: delay counter=0, idx=0, busy=1.
  - START: addr_select=16'hFE00, we=0. This makes the bus look owned and locks the CPU out of OAM. After START_DELAY clocks, go to XFER with phase=0.
  - XFER: per byte, phase counts 0..BYTE_PERIOD-1.
    - phase 0..READ_LATENCY: addr_select={src_page,idx}; we=0.
    - At phase==READ_LATENCY: latch dma_req.read_out into data_q.
    - phase READ_LATENCY+1: addr_select=16'hFE00+idx; write_value=data_q; we=1 for exactly one clock.
    - Remaining phases: addr_select=16'hFE00+idx; we=0.
    - At phase wrap, idx++. After the write of idx=159, go to IDLE with busy=0 on the next clock.
- idx is 8 bits, range 0..159. It never wraps past 159; the source low byte is idx.
- Total transfer length is START_DELAY + 160*BYTE_PERIOD clocks. Default: 644.
- Restart: a register write in START or XFER reloads src_page, sets idx=0 and delay=0, and re-enters START. A partially completed byte's write is not performed. busy stays high.
- A register write on the same clock as the final OAM write: the final write occurs, then the engine restarts (START). busy stays high.
- CPU writes to other addresses are ignored, whatever the state.

Optional Feature:
- OAM_DMA_ECHO_MIRROR_EN
  - Defined: source pages 0xE0–0xFF are remapped to page-0x20 (WRAM C000–DFFF), matching DMG echo behaviour. dma_reg still reads back the written value.
  - Undefined: src_page is used verbatim.

Decomposition:
- gb_mem_pkg holds:
  - OAM_BASE=16'hFE00, OAM_LEN=160
  - DMA_REG_ADDR=16'hFF46
  - BUS_IDLE_ADDR=16'hFFFF
  - typedef enum logic [1:0] {DMA_IDLE, DMA_START, DMA_XFER} dma_state_t
- The MMU and PPU reuse these constants.
- Single module; no natural sub-module.

Test Plan:
- Reset values:
  - Stimulus: hold rst low, release.
  - Required: addr 16'hFFFF, we 0, busy 0; reading FF46 returns 8'hFF.
- Basic copy:
  - Stimulus: WRAM model C000+i = i^8'h5A; write 8'hC0 to FF46.
  - Required: busy high for 644 clocks; exactly 160 we pulses; OAM FE00+i = i^8'h5A; FE9F = 8'hC5; bus returns to 16'hFFFF.
- Timing:
  - Stimulus: same transfer, default parameters.
  - Required: first source address C000 appears on clock 5 after the write; first OAM write is 2 clocks later; successive writes are exactly 4 clocks apart.
- Restart mid-transfer:
  - Stimulus: write 8'hC0; after 50 bytes, write 8'hD0.
  - Required: next source address after START is D000; final OAM contents are all from D000–D09F; FF46 reads 8'hD0.
- Async reset mid-transfer:
  - Stimulus: drop rst at byte 80, between clock edges.
  - Required: addr immediately 16'hFFFF, we 0; FE50.. unchanged thereafter.
- Echo mirror:
  - Stimulus: write 8'hE1.
  - Required with OAM_DMA_ECHO_MIRROR_EN: sources C100–C19F; FF46 reads 8'hE1.
  - Required without it: sources E100–E19F.
